// File: rtl/conv_bias_stream_pkg.sv
// rtl/conv_bias_stream_pkg.sv - shared types and arithmetic helpers for the conv bias stream
package conv_bias_stream_pkg;

  localparam int W_ACC = 64;

  typedef logic signed [W_ACC-1:0] acc_t;

  typedef struct packed {
    logic valid;
    logic last;
  } p_tag_t;

  function automatic int lane_idx(input int ch, input int pix, input int pic_num);
    return ch * pic_num + pix;
  endfunction

  function automatic int ch_shift(input int ch_out);
    return $clog2(ch_out);
  endfunction

  // Treats the low w bits of v as a signed value and widens it to W_ACC.
  function automatic acc_t sext(input acc_t v, input int w);
    acc_t t;
    t = v <<< (W_ACC - w);
    return t >>> (W_ACC - w);
  endfunction

  function automatic acc_t sat_clamp(input acc_t v, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo_count.sv
// rtl/sync_fifo_count.sv - synchronous FIFO with registered read data and occupancy count
module sync_fifo_count #(
  parameter int DW = 32,
  parameter int AB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AB:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AB;

  logic [DW-1:0] mem [DEPTH];
  logic [AB-1:0] wptr;
  logic [AB-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == (AB + 1)'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign do_wr = wr_en & ~full & ~clr;
  assign do_rd = rd_en & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_bias_stream.sv
// rtl/conv_bias_stream.sv - buffered conv accumulator stream with per-channel bias bank and saturation
module conv_bias_stream
  import conv_bias_stream_pkg::*;
#(
  parameter int PICTURE_NUM    = 1,
  parameter int CH_OUT         = 8,
  parameter int W_IN           = 32,
  parameter int W_BIAS         = 32,
  parameter int W_OUT          = 48,
  parameter int W_SAT          = 32,
  parameter int FIFO_ADDR_BITS = 10,
  parameter int BIAS_ADDR_BITS = 7,
  parameter int W_CH_REG       = 10,
  parameter int W_PIX          = 20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Next_Reg,
  input  logic [PICTURE_NUM*CH_OUT*W_IN-1:0]  S_Data,
  input  logic                                S_Valid,
  output logic                                S_Ready,
  input  logic                                bias_wr_en,
  input  logic [BIAS_ADDR_BITS-1:0]           bias_wr_addr,
  input  logic [CH_OUT*W_BIAS-1:0]            bias_wr_data,
  input  logic [W_CH_REG-1:0]                 Channel_Out_Num_REG,
  input  logic [W_PIX-1:0]                    Pixel_Num_REG,
  input  logic                                Sat_En,
  output logic [PICTURE_NUM*CH_OUT*W_OUT-1:0] M_Data,
  output logic                                M_Valid,
  input  logic                                M_Ready,
  output logic                                Frame_Done,
  output logic [FIFO_ADDR_BITS:0]             Fifo_Count
);

  localparam int LANES      = PICTURE_NUM * CH_OUT;
  localparam int DW         = LANES * W_IN;
  localparam int BW         = CH_OUT * W_BIAS;
  localparam int CH_SHIFT   = ch_shift(CH_OUT);
  localparam int BIAS_DEPTH = 1 << BIAS_ADDR_BITS;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_rd;
  logic                 adv;
  logic [DW-1:0]        p1_data;
  logic [BW-1:0]        bias_bank [BIAS_DEPTH];
  logic [BW-1:0]        p1_bias;
  p_tag_t               p1_tag;
  logic                 p2_last;
  logic [W_PIX-1:0]     pix_cnt;
  logic [W_PIX-1:0]     pix_max;
  logic [W_CH_REG-1:0]  grp_cnt;
  logic [W_CH_REG-1:0]  grp_max;
  logic [W_CH_REG-1:0]  ch_times;
  logic                 pix_wrap;
  logic                 grp_wrap;
  logic [LANES*W_OUT-1:0] sum_beat;
  acc_t                 lane_sum;

  assign adv        = M_Ready | ~M_Valid;
  assign fifo_rd    = adv & ~fifo_empty;
  assign S_Ready    = ~fifo_full;
  assign Frame_Done = M_Valid & M_Ready & p2_last;

  sync_fifo_count #(
    .DW(DW),
    .AB(FIFO_ADDR_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (Next_Reg),
    .wr_en   (S_Valid),
    .wr_data (S_Data),
    .rd_en   (fifo_rd),
    .rd_data (p1_data),
    .count   (Fifo_Count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Zero channel groups or zero pixels per group behave as one.
  assign ch_times = Channel_Out_Num_REG >> CH_SHIFT;
  assign grp_max  = (ch_times == '0) ? '0 : ch_times - 1'b1;
  assign pix_max  = (Pixel_Num_REG == '0) ? '0 : Pixel_Num_REG - 1'b1;
  assign pix_wrap = (pix_cnt >= pix_max);
  assign grp_wrap = (grp_cnt >= grp_max);

  always_ff @(posedge clk) begin
    if (bias_wr_en) bias_bank[bias_wr_addr] <= bias_wr_data;
  end

  always_comb begin
    sum_beat = '0;
    lane_sum = '0;
    for (int j = 0; j < CH_OUT; j++) begin
      for (int i = 0; i < PICTURE_NUM; i++) begin
        lane_sum = sext(acc_t'(p1_data[lane_idx(j, i, PICTURE_NUM)*W_IN +: W_IN]), W_IN)
                 + sext(acc_t'(p1_bias[j*W_BIAS +: W_BIAS]), W_BIAS);
        sum_beat[lane_idx(j, i, PICTURE_NUM)*W_OUT +: W_OUT] =
          W_OUT'(Sat_En ? sat_clamp(lane_sum, W_SAT) : lane_sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      grp_cnt <= '0;
      p1_bias <= '0;
      p1_tag  <= '0;
      p2_last <= 1'b0;
      M_Valid <= 1'b0;
      M_Data  <= '0;
    end else if (Next_Reg) begin
      pix_cnt <= '0;
      grp_cnt <= '0;
      p1_bias <= '0;
      p1_tag  <= '0;
      p2_last <= 1'b0;
      M_Valid <= 1'b0;
      M_Data  <= '0;
    end else begin
      if (fifo_rd) begin
        p1_bias     <= bias_bank[BIAS_ADDR_BITS'(grp_cnt)];
        p1_tag.last <= pix_wrap & grp_wrap;
        if (pix_wrap) begin
          pix_cnt <= '0;
          grp_cnt <= grp_wrap ? '0 : grp_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      // Both stages only move together; a stalled output freezes P1 as well.
      if (adv) begin
        p1_tag.valid <= fifo_rd;
        M_Valid      <= p1_tag.valid;
        p2_last      <= p1_tag.valid & p1_tag.last;
        if (p1_tag.valid) M_Data <= sum_beat;
      end
    end
  end

endmodule

// File: tb/tb_conv_bias_stream.sv
// tb/tb_conv_bias_stream.sv - scoreboard bench for conv_bias_stream
module tb_conv_bias_stream;

  localparam int CH = 8;
  localparam int DW = 256;
  localparam int OW = 384;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Next_Reg = 1'b0;
  logic [DW-1:0] S_Data = '0;
  logic          S_Valid = 1'b0;
  logic          S_Ready;
  logic          bias_wr_en = 1'b0;
  logic [6:0]    bias_wr_addr = '0;
  logic [255:0]  bias_wr_data = '0;
  logic [9:0]    Channel_Out_Num_REG = 10'd8;
  logic [19:0]   Pixel_Num_REG = 20'd1;
  logic          Sat_En = 1'b0;
  logic [OW-1:0] M_Data;
  logic          M_Valid;
  logic          M_Ready = 1'b0;
  logic          Frame_Done;
  logic [10:0]   Fifo_Count;

  always #5 clk = ~clk;

  conv_bias_stream dut (
    .clk                 (clk),
    .rst                 (rst),
    .Next_Reg            (Next_Reg),
    .S_Data              (S_Data),
    .S_Valid             (S_Valid),
    .S_Ready             (S_Ready),
    .bias_wr_en          (bias_wr_en),
    .bias_wr_addr        (bias_wr_addr),
    .bias_wr_data        (bias_wr_data),
    .Channel_Out_Num_REG (Channel_Out_Num_REG),
    .Pixel_Num_REG       (Pixel_Num_REG),
    .Sat_En              (Sat_En),
    .M_Data              (M_Data),
    .M_Valid             (M_Valid),
    .M_Ready             (M_Ready),
    .Frame_Done          (Frame_Done),
    .Fifo_Count          (Fifo_Count)
  );

  typedef struct {
    logic [OW-1:0] d;
    bit            last;
  } exp_t;

  exp_t   q[$];
  longint bmod[128][CH];
  int     m_pix, m_grp, pmax, gmax;
  bit     sat_m;
  int     checks = 0;
  int     errors = 0;
  int     flush_cnt = 0;
  int     outs = 0;
  int     fd_cnt = 0;
  int     rdy_mode = 1;

  // Ready driver: 0 = hold low, 1 = hold high, 2 = random.
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) M_Ready = 1'b0;
    else if (rdy_mode == 1) M_Ready = 1'b1;
    else M_Ready = 1'($urandom_range(0, 1));
  end

  exp_t          e;
  bit            was_stall = 0;
  logic [OW-1:0] stall_data;
  int            seen_flush = 0;

  always @(negedge clk) begin
    if (flush_cnt != seen_flush) begin
      seen_flush = flush_cnt;
      was_stall  = 0;
    end
    if (rst) begin
      if (was_stall) begin
        checks++;
        if (!(M_Valid === 1'b1 && M_Data === stall_data)) begin
          errors++;
          $display("FAIL stall_hold actual=%0b/%h required=1/%h", M_Valid, M_Data, stall_data);
        end
      end
      if (M_Valid && M_Ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", M_Data);
        end else begin
          e = q.pop_front();
          outs++;
          if (M_Data !== e.d) begin
            errors++;
            $display("FAIL m_data actual=%h required=%h", M_Data, e.d);
          end
          checks++;
          if (Frame_Done !== e.last) begin
            errors++;
            $display("FAIL frame_done actual=%0b required=%0b", Frame_Done, e.last);
          end
          if (Frame_Done === 1'b1) fd_cnt++;
        end
      end else begin
        checks++;
        if (Frame_Done !== 1'b0) begin
          errors++;
          $display("FAIL frame_done_idle actual=%0b required=0", Frame_Done);
        end
      end
      was_stall  = M_Valid && !M_Ready;
      stall_data = M_Data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] model(input logic [DW-1:0] d, input int g, input bit sat);
    logic [OW-1:0]      r;
    logic signed [31:0] a;
    longint             s;
    r = '0;
    for (int j = 0; j < CH; j++) begin
      a = d[j*32 +: 32];
      s = longint'(a) + bmod[g][j];
      if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
      if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
      r[j*48 +: 48] = s[47:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] beat(input int base);
    logic [DW-1:0] r;
    for (int j = 0; j < CH; j++) r[j*32 +: 32] = 32'(base * 8 + j);
    return r;
  endfunction

  task automatic write_bias(input int g, input longint v);
    logic [31:0] v32;
    v32 = v[31:0];
    bias_wr_en   = 1'b1;
    bias_wr_addr = 7'(g);
    bias_wr_data = {CH{v32}};
    for (int j = 0; j < CH; j++) bmod[g][j] = v;
    cycle();
    bias_wr_en = 1'b0;
  endtask

  task automatic layer_clear();
    Next_Reg = 1'b1;
    cycle();
    Next_Reg = 1'b0;
    q.delete();
    flush_cnt++;
    m_pix = 0;
    m_grp = 0;
  endtask

  task automatic set_layer(input int ch, input int pix, input bit sat);
    Channel_Out_Num_REG = 10'(ch);
    Pixel_Num_REG = 20'(pix);
    Sat_En = sat;
    sat_m = sat;
    pmax = (pix == 0) ? 0 : pix - 1;
    gmax = ((ch >> 3) == 0) ? 0 : (ch >> 3) - 1;
    layer_clear();
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    exp_t x;
    x.d = model(d, m_grp, sat_m);
    x.last = (m_pix == pmax) && (m_grp == gmax);
    q.push_back(x);
    if (m_pix == pmax) begin
      m_pix = 0;
      m_grp = (m_grp == gmax) ? 0 : m_grp + 1;
    end else begin
      m_pix++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    S_Data  = d;
    S_Valid = 1'b1;
    while (!S_Ready && n < 2000) begin
      cycle();
      n++;
    end
    if (!S_Ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=blocked required=accepted");
    end else begin
      cycle();
      push_exp(d);
    end
    S_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || M_Valid) && n < 5000) begin
      cycle();
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    while (!M_Valid && n < 50) begin
      cycle();
      n++;
    end
    chk("wait_mvalid", 64'(M_Valid), 64'd1);
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [DW-1:0] d;
    int            n, o0, f0;

    repeat (3) cycle();
    chk("rst_m_valid", 64'(M_Valid), 64'd0);
    chk("rst_s_ready", 64'(S_Ready), 64'd1);
    chk("rst_count", 64'(Fifo_Count), 64'd0);
    chk("rst_m_data", 64'(|M_Data), 64'd0);
    chk("rst_frame_done", 64'(Frame_Done), 64'd0);
    rst = 1'b1;
    cycle();

    // Single beat: latency and -7 + 5
    write_bias(0, 5);
    set_layer(8, 1, 0);
    d = '0;
    d[31:0] = 32'hFFFF_FFF9;
    S_Data  = d;
    S_Valid = 1'b1;
    cycle();
    S_Valid = 1'b0;
    push_exp(d);
    chk("lat_edge1", 64'(M_Valid), 64'd0);
    cycle();
    chk("lat_edge2", 64'(M_Valid), 64'd0);
    cycle();
    chk("lat_edge3", 64'(M_Valid), 64'd1);
    chk("single_lane0", 64'(M_Data[47:0]), 64'h0000_FFFF_FFFF_FFFE);
    chk("single_lane1", 64'(M_Data[95:48]), 64'd5);
    drain();

    // Two channel groups of three pixels
    write_bias(0, 100);
    write_bias(1, 200);
    set_layer(16, 3, 0);
    f0 = fd_cnt;
    for (int i = 0; i < 6; i++) send('0);
    drain();
    chk("two_group_frames", 64'(fd_cnt - f0), 64'd1);

    // Saturation
    write_bias(0, 256);
    set_layer(8, 1, 1);
    d = '0;
    d[31:0]  = 32'h7FFF_FFF0;
    d[63:32] = 32'h8000_0000;
    d[95:64] = 32'd5;
    send(d);
    wait_mvalid();
    chk("sat_hi", 64'(M_Data[47:0]), 64'h0000_7FFF_FFFF);
    chk("sat_inrange_neg", 64'(M_Data[95:48]), 64'h0000_FFFF_8000_0100);
    chk("sat_small", 64'(M_Data[143:96]), 64'h105);
    drain();
    write_bias(0, -1);
    set_layer(8, 1, 1);
    d = '0;
    d[31:0]  = 32'h8000_0000;
    d[63:32] = 32'h7FFF_FFFF;
    send(d);
    wait_mvalid();
    chk("sat_lo", 64'(M_Data[47:0]), 64'h0000_FFFF_8000_0000);
    chk("sat_near_max", 64'(M_Data[95:48]), 64'h0000_7FFF_FFFE);
    drain();
    write_bias(0, 256);
    set_layer(8, 1, 0);
    d = '0;
    d[31:0] = 32'h7FFF_FFF0;
    send(d);
    wait_mvalid();
    chk("nosat_wide", 64'(M_Data[47:0]), 64'h0000_8000_00F0);
    drain();

    // Fill to full with the output stalled
    write_bias(0, 3);
    set_layer(8, 1, 0);
    rdy_mode = 0;
    cycle();
    o0 = outs;
    n = 0;
    S_Valid = 1'b1;
    while (S_Ready && n < 1100) begin
      S_Data = beat(n);
      cycle();
      push_exp(beat(n));
      n++;
    end
    chk("full_count", 64'(Fifo_Count), 64'd1024);
    chk("full_accepted", 64'(n), 64'd1026);
    chk("full_s_ready", 64'(S_Ready), 64'd0);
    S_Data = beat(5000);
    repeat (3) cycle();
    chk("full_hold_count", 64'(Fifo_Count), 64'd1024);
    S_Valid = 1'b0;
    rdy_mode = 1;
    drain();
    chk("full_outs", 64'(outs - o0), 64'd1026);

    // Random backpressure over 500 beats, 4 groups x 5 pixels
    write_bias(0, -50000);
    write_bias(1, 7);
    write_bias(2, 123456);
    write_bias(3, -1);
    set_layer(32, 5, 0);
    rdy_mode = 2;
    o0 = outs;
    f0 = fd_cnt;
    for (int i = 0; i < 500; i++) begin
      for (int j = 0; j < CH; j++) d[j*32 +: 32] = $urandom;
      send(d);
      if ($urandom_range(0, 3) == 0) cycle();
    end
    rdy_mode = 1;
    drain();
    chk("rand_outs", 64'(outs - o0), 64'd500);
    chk("rand_frames", 64'(fd_cnt - f0), 64'd25);

    // Soft clear mid-stream, then a fresh layer on the loaded biases
    set_layer(16, 3, 0);
    rdy_mode = 0;
    cycle();
    for (int i = 0; i < 5; i++) send(beat(i));
    cycle();
    layer_clear();
    chk("nr_m_valid", 64'(M_Valid), 64'd0);
    chk("nr_count", 64'(Fifo_Count), 64'd0);
    chk("nr_s_ready", 64'(S_Ready), 64'd1);
    rdy_mode = 1;
    o0 = outs;
    for (int i = 0; i < 6; i++) send('0);
    drain();
    chk("nr_outs", 64'(outs - o0), 64'd6);

    // Async reset mid-stream
    rdy_mode = 0;
    cycle();
    for (int i = 0; i < 4; i++) send(beat(i + 10));
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_m_valid", 64'(M_Valid), 64'd0);
    chk("rst_mid_count", 64'(Fifo_Count), 64'd0);
    chk("rst_mid_s_ready", 64'(S_Ready), 64'd1);
    chk("rst_mid_m_data", 64'(|M_Data), 64'd0);
    q.delete();
    flush_cnt++;
    m_pix = 0;
    m_grp = 0;
    rst = 1'b1;
    cycle();
    rdy_mode = 1;
    o0 = outs;
    for (int i = 0; i < 6; i++) send(beat(i + 20));
    drain();
    chk("rst_mid_outs", 64'(outs - o0), 64'd6);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
